// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 clock, deframes
// 11-bit frames, and decodes E0/F0 prefixes into single key events.
module ps2_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 1200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_release,
   output logic       key_extended,
   output logic       rx_error,
   output logic       busy
);

   localparam logic [7:0] FILT_MAX = 8'(FILTER_LEN - 1);
   localparam int         WD_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t          state;
   state_t          state_next;
   logic [1:0]      clk_sync;
   logic [1:0]      data_sync;
   logic            clk_s;
   logic            bit_in;
   logic            clk_filt;
   logic [7:0]      filt_cnt;
   logic            fall;
   logic [WD_W-1:0] wd_cnt;
   logic            timeout;
   logic [2:0]      bit_cnt;
   logic [2:0]      bit_cnt_next;
   logic [7:0]      shift;
   logic [7:0]      shift_next;
   logic            perr;
   logic            perr_next;
   logic            frame_ok;
   logic            frame_bad;
   logic            rel_flag;
   logic            ext_flag;

   assign clk_s  = clk_sync[1];
   assign bit_in = data_sync[1];
   assign busy   = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   // Filtered level only follows after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_filt <= 1'b1;
         filt_cnt <= 8'd0;
         fall     <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (clk_s == clk_filt) begin
            filt_cnt <= 8'd0;
         end else if (filt_cnt == FILT_MAX) begin
            clk_filt <= clk_s;
            filt_cnt <= 8'd0;
            fall     <= clk_filt;
         end else begin
            filt_cnt <= filt_cnt + 8'd1;
         end
      end
   end

   assign timeout = (state != IDLE) && !fall && (wd_cnt == WD_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if (state == IDLE || fall || timeout) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= 3'd0;
         shift   <= 8'd0;
         perr    <= 1'b0;
      end else begin
         state   <= state_next;
         bit_cnt <= bit_cnt_next;
         shift   <= shift_next;
         perr    <= perr_next;
      end
   end

   // A timeout can only fire in a cycle without a fall, so it never races a frame end.
   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      shift_next   = shift;
      perr_next    = perr;
      frame_ok     = 1'b0;
      frame_bad    = 1'b0;
      case (state)
         IDLE: begin
            if (fall && !bit_in) begin
               state_next   = DATA;
               bit_cnt_next = 3'd0;
               perr_next    = 1'b0;
            end
         end
         DATA: begin
            if (fall) begin
               shift_next   = {bit_in, shift[7:1]};
               bit_cnt_next = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state_next = PARITY;
               end
            end
         end
         PARITY: begin
            if (fall) begin
               perr_next  = ~(^{shift, bit_in});
               state_next = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               if (bit_in && !perr) begin
                  frame_ok = 1'b1;
               end else begin
                  frame_bad = 1'b1;
               end
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (timeout) begin
         state_next = IDLE;
         frame_bad  = 1'b1;
      end
   end

   // Prefix bytes only arm flags; any other good byte emits the event and consumes them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_valid    <= 1'b0;
         rx_error     <= 1'b0;
         key_code     <= 8'h00;
         key_release  <= 1'b0;
         key_extended <= 1'b0;
         rel_flag     <= 1'b0;
         ext_flag     <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         rx_error  <= 1'b0;
         if (frame_bad) begin
            rx_error <= 1'b1;
            rel_flag <= 1'b0;
            ext_flag <= 1'b0;
         end else if (frame_ok) begin
            if (shift == 8'hE0) begin
               ext_flag <= 1'b1;
            end else if (shift == 8'hF0) begin
               rel_flag <= 1'b1;
            end else begin
               key_valid    <= 1'b1;
               key_code     <= shift;
               key_release  <= rel_flag;
               key_extended <= ext_flag;
               rel_flag     <= 1'b0;
               ext_flag     <= 1'b0;
            end
         end
      end
   end

endmodule
